// File: rtl/vector_sweep_ctrl.sv
// Exhaustive input-sweep sequencer: drives every N_IN-bit vector (ascending) into a logic block and compares the sampled outputs against golden values.
// Latency: each vector is held SETTLE cycles plus one sample cycle, so a sweep completes 2^N_IN*(SETTLE+1) cycles after start is accepted.
// Backpressure: none. start is ignored while busy; abort cancels a running sweep; results hold until the next accepted start.
//
// Ports:
//   clk, rst_n        single rising-edge clock, asynchronous active-low reset
//   start, abort      sweep request / cancel (both sampled on clk)
//   vec_out           stimulus to the block under test (bit3=A .. bit0=D)
//   resp_in, exp_in   block outputs and golden outputs for the current vec_out
//   busy, done, pass  sweep status; done and pass are sticky until the next start
//   err_count         mismatching vectors, saturating at 2^N_IN
//   first_err_*       vector and response of the first mismatch
module vector_sweep_ctrl #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [N_IN-1:0]   vec_out,
  input  logic [N_OUT-1:0]  resp_in,
  input  logic [N_OUT-1:0]  exp_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic              first_err_valid,
  output logic [N_IN-1:0]   first_err_vec,
  output logic [N_OUT-1:0]  first_err_resp
);

  localparam int          CW      = 4;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN:0]   ERR_MAX  = (N_IN + 1)'(1 << N_IN);
  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_IN-1:0]    vec_q, vec_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [N_IN:0]      err_q, err_d;
  logic               fe_vld_q, fe_vld_d;
  logic [N_IN-1:0]    fe_vec_q, fe_vec_d;
  logic [N_OUT-1:0]   fe_resp_q, fe_resp_d;

  logic               mismatch;
  logic [N_IN:0]      err_inc;

  assign mismatch = (resp_in != exp_in);
  assign err_inc  = (err_q == ERR_MAX) ? err_q : err_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    vec_d     = vec_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    fe_vld_d  = fe_vld_q;
    fe_vec_d  = fe_vec_q;
    fe_resp_d = fe_resp_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // A start from DONE is identical to one from IDLE: results are wiped.
        if (start) begin
          state_d   = ST_SETTLE;
          cnt_d     = '0;
          vec_d     = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          err_d     = '0;
          fe_vld_d  = 1'b0;
          fe_vec_d  = '0;
          fe_resp_d = '0;
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          vec_d   = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Up-counter from 0 to SETTLE-1 gives exactly SETTLE cycles here.
          state_d = ST_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SAMPLE: begin
        // abort wins over the compare: the partial results are left untouched.
        if (abort) begin
          state_d = ST_IDLE;
          vec_d   = '0;
          busy_d  = 1'b0;
        end else begin
          if (mismatch) begin
            err_d = err_inc;
            if (!fe_vld_q) begin
              fe_vld_d  = 1'b1;
              fe_vec_d  = vec_q;
              fe_resp_d = resp_in;
            end
          end
          if (vec_q != VEC_LAST) begin
            state_d = ST_SETTLE;
            vec_d   = vec_q + 1'b1;
          end else begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // Uses the post-update count so a miss on the last vector fails.
            pass_d  = (err_d == '0);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      vec_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      fe_vld_q  <= 1'b0;
      fe_vec_q  <= '0;
      fe_resp_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vec_q     <= vec_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      fe_vld_q  <= fe_vld_d;
      fe_vec_q  <= fe_vec_d;
      fe_resp_q <= fe_resp_d;
    end
  end

  assign vec_out         = vec_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fe_vld_q;
  assign first_err_vec   = fe_vec_q;
  assign first_err_resp  = fe_resp_q;

endmodule

// File: tb/tb_vector_sweep_ctrl.sv
// Directed bench for vector_sweep_ctrl: golden, stuck-at, inverted, abort, reset and start-filter scenarios.
// Golden block: W1 = D | (A & (B | C)), W2 = B XNOR D.
// Inputs change on the falling edge; outputs are observed on the falling edge.
module tb_vector_sweep_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] vec_out;
  logic [1:0] resp_in;
  logic [1:0] exp_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic       first_err_valid;
  logic [3:0] first_err_vec;
  logic [1:0] first_err_resp;

  int checks = 0;
  int errors = 0;
  int mode   = 0;  // 0: golden, 1: W1 stuck-at-0, 2: inverted

  vector_sweep_ctrl #(.N_IN(4), .N_OUT(2), .SETTLE(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .vec_out         (vec_out),
    .resp_in         (resp_in),
    .exp_in          (exp_in),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_err_valid (first_err_valid),
    .first_err_vec   (first_err_vec),
    .first_err_resp  (first_err_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] golden(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return {d | (a & (b | c)), ~(b ^ d)};
  endfunction

  always_comb begin
    exp_in = golden(vec_out);
    case (mode)
      1:       resp_in = {1'b0, exp_in[0]};
      2:       resp_in = ~exp_in;
      default: resp_in = exp_in;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns on the falling edge right after the accepting rising edge.
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges until done; also checks vector order and busy.
  task automatic wait_done(input bit pulse_start, output int cycles, output int bad);
    cycles = 0;
    bad    = 0;
    while (!done && cycles < 200) begin
      if (vec_out !== 4'(cycles / 3) || busy !== 1'b1) bad++;
      start = pulse_start && (cycles % 10 == 9);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
  endtask

  initial begin
    int cyc;
    int bad;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_vec",  32'(vec_out), 32'd0);
    chk("rst_err",  32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Golden sweep
    mode = 0;
    do_start();
    wait_done(1'b0, cyc, bad);
    chk("gold_latency", 32'(cyc), 32'd48);
    chk("gold_order",   32'(bad), 32'd0);
    chk("gold_pass",    32'(pass), 32'd1);
    chk("gold_err",     32'(err_count), 32'd0);
    chk("gold_fev",     32'(first_err_valid), 32'd0);
    chk("gold_busy",    32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("gold_hold_done", 32'(done), 32'd1);
    chk("gold_hold_vec",  32'(vec_out), 32'd15);

    // W1 stuck-at-0
    mode = 1;
    do_start();
    wait_done(1'b0, cyc, bad);
    chk("w1sa0_latency", 32'(cyc), 32'd48);
    chk("w1sa0_err",     32'(err_count), 32'd11);
    chk("w1sa0_pass",    32'(pass), 32'd0);
    chk("w1sa0_fev",     32'(first_err_valid), 32'd1);
    chk("w1sa0_fvec",    32'(first_err_vec), 32'd1);
    chk("w1sa0_fresp",   32'(first_err_resp), 32'd0);

    // All responses inverted: count reaches 16 without wrapping
    mode = 2;
    do_start();
    wait_done(1'b0, cyc, bad);
    chk("inv_err",   32'(err_count), 32'd16);
    chk("inv_pass",  32'(pass), 32'd0);
    chk("inv_fvec",  32'(first_err_vec), 32'd0);
    chk("inv_fresp", 32'(first_err_resp), 32'd2);

    // Abort in SAMPLE of vector 5 with start also high
    mode = 1;
    do_start();
    repeat (17) @(negedge clk);
    chk("abort_pre_vec", 32'(vec_out), 32'd5);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_pass", 32'(pass), 32'd0);
    chk("abort_vec",  32'(vec_out), 32'd0);
    chk("abort_err",  32'(err_count), 32'd2);
    chk("abort_fvec", 32'(first_err_vec), 32'd1);
    repeat (3) @(negedge clk);
    chk("abort_idle_busy", 32'(busy), 32'd0);
    mode = 0;
    do_start();
    wait_done(1'b0, cyc, bad);
    chk("post_abort_latency", 32'(cyc), 32'd48);
    chk("post_abort_order",   32'(bad), 32'd0);
    chk("post_abort_pass",    32'(pass), 32'd1);

    // Reset mid-SETTLE of vector 7
    mode = 1;
    do_start();
    repeat (21) @(negedge clk);
    chk("rst_pre_vec", 32'(vec_out), 32'd7);
    chk("rst_pre_err", 32'(err_count), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("arst_vec",  32'(vec_out), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_err",  32'(err_count), 32'd0);
    chk("arst_fev",  32'(first_err_valid), 32'd0);
    chk("arst_fvec", 32'(first_err_vec), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mode = 0;
    do_start();
    wait_done(1'b0, cyc, bad);
    chk("post_rst_latency", 32'(cyc), 32'd48);
    chk("post_rst_order",   32'(bad), 32'd0);
    chk("post_rst_pass",    32'(pass), 32'd1);

    // start pulses while busy are ignored; start in DONE restarts
    mode = 2;
    do_start();
    wait_done(1'b1, cyc, bad);
    chk("busy_start_latency", 32'(cyc), 32'd48);
    chk("busy_start_order",   32'(bad), 32'd0);
    chk("busy_start_err",     32'(err_count), 32'd16);
    do_start();
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_vec",  32'(vec_out), 32'd0);
    chk("restart_err",  32'(err_count), 32'd0);
    chk("restart_fev",  32'(first_err_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
